isa_burst_responder: RTL

DDR-side responder for instruction-cache fetch requests. It accepts a read request (ISA_read_req/ISA_read_addr/isa_read_len) from the instruction cache and issues one burst read on the DDR controller's native burst interface. It streams each returned beat back as instruction_to_cache with a running beat count rd_cnt_isa and a per-beat valid. The block sits inside the DDR interface, between the instruction cache and the DDR burst controller.

---
 rtl/ap_ddr_pkg.sv | 25 ++
 rtl/isa_burst_responder.sv | 123 ++++++++++++
 2 files changed

// File: rtl/ap_ddr_pkg.sv
// ap_ddr_pkg: shared DDR-side constants, instruction layout and responder states.
package ap_ddr_pkg;
  localparam int OPCODE_W       = 4;
  localparam int CAM_ADDR_W     = 8;
  localparam int OPERAND2_W     = 2;
  localparam int MEM_ADDR_W     = 16;
  localparam int ISA_W          = OPCODE_W + CAM_ADDR_W + OPERAND2_W + MEM_ADDR_W;
  localparam int MAX_BURST      = 128;
  localparam int LEN_W          = 10;
  localparam int ISA_ADDR_SCALE = 8;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DATA  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } isa_resp_state_e;
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len, input int max_len);
    return (int'(len) > max_len) ? LEN_W'(max_len) : len;
  endfunction
  // Byte address of the idx-th instruction; the cache uses the same scale.
  function automatic int unsigned isa_byte_addr(input int unsigned idx);
    return idx * ISA_ADDR_SCALE;
  endfunction
endpackage

// File: rtl/isa_burst_responder.sv
// isa_burst_responder: turns one instruction-cache fetch into a DDR burst read
// and streams each returned beat back to the cache one cycle later.
module isa_burst_responder
  import ap_ddr_pkg::*;
#(
  parameter int          DDR_ADDR_WIDTH = 28,
  parameter int          DDR_DATA_WIDTH = 64,
  parameter int          ISA_WIDTH      = ISA_W,
  parameter int          MAX_BURST_LEN  = MAX_BURST,
  parameter int unsigned ISA_BASE_ADDR  = 0,
  parameter int          TIMEOUT_CYCLES = 1023
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ISA_read_req,
  input  logic [DDR_ADDR_WIDTH-1:0] ISA_read_addr,
  input  logic [LEN_W-1:0]          isa_read_len,
  output logic [ISA_WIDTH-1:0]      instruction_to_cache,
  output logic [LEN_W-1:0]          rd_cnt_isa,
  output logic                      rd_burst_data_valid,
  output logic                      isa_busy,
  output logic                      isa_err,
  output logic [2:0]                st_cur_isa_resp,
  output logic                      rd_burst_req,
  output logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
  output logic [LEN_W-1:0]          rd_burst_len,
  input  logic [DDR_DATA_WIDTH-1:0] rd_burst_data,
  input  logic                      rd_burst_data_valid_in,
  input  logic                      rd_burst_finish
);
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  isa_resp_state_e state_q, state_d;
  logic [DDR_ADDR_WIDTH-1:0] addr_d;
  logic [LEN_W-1:0] len_d, cnt_d, accept_len;
  logic [ISA_WIDTH-1:0] ins_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic req_d, vld_d, busy_d, err_d, beat, timeout;
  logic unused_hi;
  assign unused_hi = ^rd_burst_data[DDR_DATA_WIDTH-1:ISA_WIDTH];
  assign beat = rd_burst_data_valid_in;
  // The watchdog expires on the TIMEOUT_CYCLES-th consecutive beatless cycle.
  assign timeout = !beat && (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));
  assign accept_len = clamp_len(isa_read_len, MAX_BURST_LEN);
  assign st_cur_isa_resp = state_q;
  always_comb begin
    state_d = state_q;
    addr_d  = rd_burst_addr;
    len_d   = rd_burst_len;
    req_d   = rd_burst_req;
    cnt_d   = rd_cnt_isa;
    ins_d   = instruction_to_cache;
    vld_d   = 1'b0;
    busy_d  = isa_busy;
    err_d   = isa_err;
    wdog_d  = wdog_q;
    case (state_q)
      IDLE: if (ISA_read_req) begin
        addr_d  = ISA_read_addr + DDR_ADDR_WIDTH'(ISA_BASE_ADDR);
        len_d   = accept_len;
        req_d   = accept_len != '0;
        cnt_d   = '0;
        err_d   = 1'b0;
        busy_d  = 1'b1;
        state_d = (accept_len == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        wdog_d  = '0;
        state_d = DATA;
      end
      DATA, DRAIN: begin
        wdog_d = beat ? '0 : wdog_q + 1'b1;
        if (state_q == DATA && beat) begin
          if (rd_cnt_isa < rd_burst_len) begin
            ins_d = rd_burst_data[ISA_WIDTH-1:0];
            cnt_d = rd_cnt_isa + 1'b1;
            vld_d = 1'b1;
          end else
            err_d = 1'b1;
        end
        // A beat arriving with finish is still delivered above.
        if (rd_burst_finish || timeout) begin
          req_d   = 1'b0;
          state_d = (state_q == DATA) ? DONE : IDLE;
          err_d   = err_d | (state_q == DATA && !rd_burst_finish);
          busy_d  = (state_q == DATA) ? busy_d : 1'b0;
          cnt_d   = (state_q == DATA) ? cnt_d : '0;
        end else if (state_q == DATA && !ISA_read_req)
          state_d = DRAIN;
      end
      DONE: if (!ISA_read_req) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q              <= IDLE;
      rd_burst_addr        <= '0;
      rd_burst_len         <= '0;
      rd_burst_req         <= 1'b0;
      rd_cnt_isa           <= '0;
      instruction_to_cache <= '0;
      rd_burst_data_valid  <= 1'b0;
      isa_busy             <= 1'b0;
      isa_err              <= 1'b0;
      wdog_q               <= '0;
    end else begin
      state_q              <= state_d;
      rd_burst_addr        <= addr_d;
      rd_burst_len         <= len_d;
      rd_burst_req         <= req_d;
      rd_cnt_isa           <= cnt_d;
      instruction_to_cache <= ins_d;
      rd_burst_data_valid  <= vld_d;
      isa_busy             <= busy_d;
      isa_err              <= err_d;
      wdog_q               <= wdog_d;
    end
  end
endmodule
